gcd_rr_arbiter: RTL and testbench
=================================

Name: gcd_rr_arbiter

Overview:
- Shares one GCD datapath unit among NUM_REQ independent requesters using round-robin arbitration.
- Latches the granted requester's operand pair and drives the GCD input handshake (input_valid pulse).
- Collects the result on output_valid and returns it to the granted requester.
- Releases the GCD with gcd_ack once the requester acknowledges.
- Sits between client blocks and the GCD instance; the GCD shares this block's clk and reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width; matches the GCD datapath.
- TIMEOUT, 255, maximum cycles in WAIT before the request is aborted with an error.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until req_ready is seen.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-cycle one-hot pulse: operands of that requester captured.
- rsp_valid  out  NUM_REQ  one-hot; held until the matching rsp_ack.
- rsp_data  out  WIDTH  result for the requester whose rsp_valid is high.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort, rsp_data = 0.
- rsp_ack  in  NUM_REQ  requester consumes its response.
- gcd_a  out  WIDTH  to GCD A_in.
- gcd_b  out  WIDTH  to GCD B_in.
- gcd_input_valid  out  1  to GCD input_valid.
- gcd_result  in  WIDTH  from GCD G_out.
- gcd_output_valid  in  1  from GCD output_valid.
- gcd_ack  out  1  to GCD gcd_ack.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE, rr_ptr = 0, grant register = 0, timeout counter = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, gcd_a, gcd_b, gcd_input_valid, gcd_ack, busy.
  - Reset mid-operation abandons the transaction; no response is issued.
- IDLE:
  - If any req_valid bit is set, grant g = first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Latch req_a[g] and req_b[g] into gcd_a and gcd_b; pulse req_ready[g] for one cycle.
  - If either latched operand is 0: rsp_data = the other operand (gcd(0,0) = 0), go to RESPOND, and skip the GCD entirely.
  - Otherwise go to ISSUE.
- ISSUE: gcd_input_valid = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - When gcd_output_valid = 1: rsp_data = gcd_result, rsp_err = 0; go to RESPOND.
  - The counter increments each cycle. When it reaches TIMEOUT with no output_valid: rsp_err = 1, rsp_data = 0; go to RESPOND.
- RESPOND:
  - rsp_valid[g] = 1 is held; rsp_data and rsp_err are stable.
  - On rsp_ack[g]: go to RELEASE if the GCD was used, otherwise IDLE.
  - rsp_ack bits other than g are ignored.
- RELEASE: gcd_ack = 1, held until gcd_output_valid = 0 (at least one cycle); then go to IDLE. On a timeout abort, one gcd_ack cycle is issued.
- Round-robin pointer: on return to IDLE, rr_ptr = (g+1) mod NUM_REQ. This guarantees no starvation: each waiting requester is served within NUM_REQ grants.
- Minimum latency: request to ISSUE is 1 cycle; ISSUE to WAIT is 1 cycle. The bypass path gives rsp_valid 1 cycle after grant.
- Boundary conditions:
  - req_valid dropped before grant: ignored.
  - New requests during a transaction: wait in place; not queued.
  - rsp_ack asserted in the same cycle rsp_valid rises: accepted.
  - gcd_output_valid outside WAIT or RELEASE: ignored.
- The operand registers stay constant from grant until IDLE, as the GCD requires.

Decomposition:
- Shared package gcd_pkg:
  - state encoding: IDLE, ISSUE, WAIT, RESPOND, RELEASE.
  - default WIDTH.
  - ZERO constant for the zero-operand check.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: NUM_REQ request vector and rr_ptr. Outputs: one-hot grant and encoded index.
- The FSM and datapath registers stay in gcd_rr_arbiter.

Test Plan:
- Single request, req0 A=21 B=18 → req_ready[0] pulse; one gcd_input_valid pulse; rsp_valid[0] with rsp_data=3, rsp_err=0; after rsp_ack, gcd_ack until output_valid low.
- All four requesters valid at once, pairs (48,18), (35,10), (17,5), (100,75) → grants in order 0,1,2,3 with results 6, 5, 1, 25. Requester 0 re-asserting immediately is served only after 3.
- Zero operand, req2 A=0 B=12 → rsp_data=12 with no gcd_input_valid pulse; A=0 B=0 → rsp_data=0.
- GCD model that never asserts output_valid → after TIMEOUT cycles rsp_valid with rsp_err=1 and rsp_data=0; next request proceeds normally.
- Reset asserted during WAIT → the next cycle has all outputs 0, busy=0, rr_ptr=0; a following request on req1 is granted first and returns the correct result.
- Delayed rsp_ack (20 cycles) → rsp_valid and rsp_data held stable; gcd_ack not asserted until the ack arrives.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD round-robin arbiter slice.
//   state_e   - arbiter FSM state encoding
//   DEF_WIDTH - default operand/result width of the shared GCD datapath
//   ZERO      - wide zero constant, sliced to WIDTH for the zero-operand check
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESPOND = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam int DEF_WIDTH = 8;

  localparam logic [63:0] ZERO = '0;

endpackage

// File: rtl/gcd_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i  - request vector, one bit per requester
//   ptr_i  - index with highest priority this round
//   gnt_o  - one-hot grant (all zero when no request)
//   idx_o  - encoded index of the granted requester
//   any_o  - at least one request present
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  logic          found;
  logic [PW-1:0] j;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = PW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: shares one GCD datapath among NUM_REQ requesters.
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/a/b       - per-requester request and packed operands
//   req_ready           - one-cycle one-hot pulse when operands are captured
//   rsp_valid/data/err  - one-hot response, held until matching rsp_ack
//   rsp_ack             - per-requester response consume
//   gcd_a/b, gcd_input_valid, gcd_result, gcd_output_valid, gcd_ack
//                       - handshake with the shared GCD unit
//   busy                - arbiter not idle
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic [NUM_REQ-1:0]       rsp_ack,
  output logic [WIDTH-1:0]         gcd_a,
  output logic [WIDTH-1:0]         gcd_b,
  output logic                     gcd_input_valid,
  input  logic [WIDTH-1:0]         gcd_result,
  input  logic                     gcd_output_valid,
  output logic                     gcd_ack,
  output logic                     busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] ZW = ZERO[WIDTH-1:0];

  state_e             state_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      g_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               used_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   gcd_a_q, gcd_b_q, rsp_data_q;
  logic [NUM_REQ-1:0] req_ready_q, rsp_valid_q;
  logic               rsp_err_q, gcd_iv_q, gcd_ack_q, busy_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [PW-1:0]      next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign a_sel    = req_a[int'(pick_idx)*WIDTH +: WIDTH];
  assign b_sel    = req_b[int'(pick_idx)*WIDTH +: WIDTH];
  assign next_ptr = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      gnt_q       <= '0;
      used_q      <= 1'b0;
      cnt_q       <= '0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      gcd_iv_q    <= 1'b0;
      gcd_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      gcd_iv_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            g_q         <= pick_idx;
            gnt_q       <= pick_gnt;
            gcd_a_q     <= a_sel;
            gcd_b_q     <= b_sel;
            req_ready_q <= pick_gnt;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
            if (a_sel == ZW || b_sel == ZW) begin
              // gcd(x,0) = x; the GCD unit is never started.
              rsp_data_q  <= (a_sel == ZW) ? b_sel : a_sel;
              rsp_valid_q <= pick_gnt;
              used_q      <= 1'b0;
              state_q     <= S_RESPOND;
            end else begin
              used_q   <= 1'b1;
              gcd_iv_q <= 1'b1;   // high for the single ISSUE cycle
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (gcd_output_valid) begin
            rsp_data_q  <= gcd_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_q;
            state_q     <= S_RESPOND;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= gnt_q;
            state_q     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (|(rsp_ack & gnt_q)) begin
            rsp_valid_q <= '0;
            if (used_q) begin
              gcd_ack_q <= 1'b1;
              state_q   <= S_RELEASE;
            end else begin
              rr_ptr_q <= next_ptr;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        S_RELEASE: begin
          // After a timeout the GCD may never raise output_valid, so one
          // ack cycle is enough.
          if (!gcd_output_valid || rsp_err_q) begin
            gcd_ack_q <= 1'b0;
            rr_ptr_q  <= next_ptr;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign gcd_a           = gcd_a_q;
  assign gcd_b           = gcd_b_q;
  assign gcd_input_valid = gcd_iv_q;
  assign gcd_ack         = gcd_ack_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// tb_gcd_rr_arbiter: directed bench for gcd_rr_arbiter with a behavioural
// GCD responder (fixed latency, can be made unresponsive).
module tb_gcd_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 255;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid, rsp_ack;
  logic [W-1:0]   rsp_data, gcd_a, gcd_b;
  logic           rsp_err, gcd_input_valid, gcd_ack, busy;
  logic [W-1:0]   gcd_result = '0;
  logic           gcd_output_valid = 1'b0;

  always #5 clk = ~clk;

  gcd_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .rsp_ack          (rsp_ack),
    .gcd_a            (gcd_a),
    .gcd_b            (gcd_b),
    .gcd_input_valid  (gcd_input_valid),
    .gcd_result       (gcd_result),
    .gcd_output_valid (gcd_output_valid),
    .gcd_ack          (gcd_ack),
    .busy             (busy)
  );

  // ---------------- GCD responder ----------------
  logic         dead = 1'b0;
  int           dly = 0;
  int           iv_cnt = 0;
  logic [W-1:0] ma = '0, mb = '0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      gcd_output_valid <= 1'b0;
      dly              <= 0;
    end else begin
      if (gcd_input_valid) begin
        iv_cnt <= iv_cnt + 1;
        if (!dead) begin
          dly <= 4;
          ma  <= gcd_a;
          mb  <= gcd_b;
        end
      end else if (dly == 1) begin
        gcd_output_valid <= 1'b1;
        gcd_result       <= ref_gcd(ma, mb);
        dly              <= 0;
      end else if (dly > 1) begin
        dly <= dly - 1;
      end
      if (gcd_output_valid && gcd_ack) gcd_output_valid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  // Serve one grant for requester idx (its req_valid already set).
  // used: 1 if a GCD pass is expected; ack_dly: cycles to hold before ack.
  task automatic serve(input int idx, input int exp, input int err, input int used,
                       input int ack_dly);
    int t;
    int iv0;
    int ga;
    int bad;
    t = 0;
    while (req_ready == 0 && t < 50) begin @(negedge clk); t++; end
    chk("grant", 32'(req_ready), 32'(1 << idx));
    iv0 = iv_cnt;
    req_valid[idx] = 1'b0;
    t = 0;
    while (rsp_valid == 0 && t < 400) begin @(negedge clk); t++; end
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_err", 32'(rsp_err), 32'(err));
    chk("iv_pulses", 32'(iv_cnt - iv0), 32'(used));
    bad = 0;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (rsp_valid != 4'(1 << idx) || rsp_data != W'(exp) || gcd_ack) bad++;
    end
    if (ack_dly > 0) chk("rsp_hold", 32'(bad), 32'd0);
    rsp_ack[idx] = 1'b1;
    @(negedge clk);
    rsp_ack[idx] = 1'b0;
    chk("rsp_clr", 32'(rsp_valid), 32'd0);
    ga = 0;
    t = 0;
    while (busy && t < 20) begin
      if (gcd_ack) ga++;
      @(negedge clk);
      t++;
    end
    chk("gcd_ack_seen", 32'(ga != 0), 32'(used));
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ack   = '0;
    repeat (3) @(negedge clk);
    chk("rst_out0", {req_ready, rsp_valid, rsp_data, rsp_err}, 32'd0);
    chk("rst_out1", {gcd_a, gcd_b, gcd_input_valid, gcd_ack, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Round robin: all four at once, then requester 0 re-asserts.
    set_op(0, 48, 18);
    set_op(1, 35, 10);
    set_op(2, 17, 5);
    set_op(3, 100, 75);
    req_valid = 4'hF;
    serve(0, 6, 0, 1, 0);
    req_valid[0] = 1'b1;
    serve(1, 5, 0, 1, 0);
    serve(2, 1, 0, 1, 0);
    serve(3, 25, 0, 1, 0);
    serve(0, 6, 0, 1, 0);

    // Single request.
    set_op(0, 21, 18);
    req_valid[0] = 1'b1;
    serve(0, 3, 0, 1, 0);

    // Zero-operand bypass.
    set_op(2, 0, 12);
    req_valid[2] = 1'b1;
    serve(2, 12, 0, 0, 0);
    set_op(2, 0, 0);
    req_valid[2] = 1'b1;
    serve(2, 0, 0, 0, 0);

    // Timeout, then a normal request.
    dead = 1'b1;
    set_op(3, 9, 6);
    req_valid[3] = 1'b1;
    serve(3, 0, 1, 1, 0);
    dead = 1'b0;
    req_valid[3] = 1'b1;
    serve(3, 3, 0, 1, 0);

    // Delayed ack.
    set_op(1, 44, 33);
    req_valid[1] = 1'b1;
    serve(1, 11, 0, 1, 20);

    // Reset while waiting on the GCD (pointer would otherwise be 3).
    dead = 1'b1;
    set_op(2, 30, 12);
    req_valid[2] = 1'b1;
    t = 0;
    while (req_ready == 0 && t < 50) begin @(negedge clk); t++; end
    chk("rst_grant", 32'(req_ready), 32'h4);
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst0", {req_ready, rsp_valid, rsp_data, rsp_err}, 32'd0);
    chk("mid_rst1", {gcd_a, gcd_b, gcd_input_valid, gcd_ack, busy}, 32'd0);
    reset = 1'b0;
    dead  = 1'b0;
    set_op(1, 27, 18);
    set_op(3, 14, 21);
    req_valid = 4'b1010;
    serve(1, 9, 0, 1, 0);
    serve(3, 7, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
